uart_tx: RTL and testbench

Serial transmitter stage of the RS232 transmit path. Consumes the oversampling tick from the upstream baud-rate tick generator, accepts one parallel word per start request, and shifts it out LSB-first as an asynchronous frame: start bit, data bits, optional parity, stop bit(s). Each bit period is 16 ticks. Emits a one-cycle completion pulse when the frame ends.

---
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter: 16 ticks per bit, LSB first, start/data/stop framing.
// Define UART_TX_PARITY_EN to insert one even-parity bit between data and stop.
module uart_tx #(
  parameter int DBit   = 8,
  parameter int SbTick = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tx_start_i,
  input  logic            s_tick_i,
  input  logic [DBit-1:0] din_i,
  output logic            tx_o,
  output logic            busy_o,
  output logic            tx_done_tick_o
);

  // state    | meaning
  // S_IDLE   | line high, waiting for tx_start_i
  // S_START  | start bit (low) for 16 ticks
  // S_DATA   | shifting out DBit data bits, LSB first
  // S_PARITY | even-parity bit (parity build only)
  // S_STOP   | stop bit(s), high for SbTick ticks
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Tick counter must also reach SbTick-1 in STOP (up to 31 for two stop bits).
  localparam int SW = (SbTick > 16) ? $clog2(SbTick) : 4;

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_s, w_s_nxt;
  logic [2:0]        r_n, w_n_nxt;
  logic [DBit-1:0]   r_b, w_b_nxt;
  logic              r_tx, w_tx_nxt;
  logic              w_done;
  logic              w_bit_end;

`ifdef UART_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_par <= 1'b0;
    else if (r_state == S_IDLE && tx_start_i)
      r_par <= ^din_i;
  end
`endif

  assign w_bit_end = s_tick_i && (r_s == SW'(15));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_start_i) begin
          w_b_nxt     = din_i;
          w_s_nxt     = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_s_nxt     = '0;
          w_n_nxt     = '0;
          w_state_nxt = S_DATA;
        end else if (s_tick_i) begin
          w_s_nxt = r_s + SW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_s_nxt = '0;
          w_b_nxt = r_b >> 1;
          if (r_n == 3'(DBit - 1))
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          else
            w_n_nxt = r_n + 3'd1;
        end else if (s_tick_i) begin
          w_s_nxt = r_s + SW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_s_nxt     = '0;
          w_state_nxt = S_STOP;
        end else if (s_tick_i) begin
          w_s_nxt = r_s + SW'(1);
        end
      end
`endif
      S_STOP: begin
        if (s_tick_i && r_s == SW'(SbTick - 1)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (s_tick_i) begin
          w_s_nxt = r_s + SW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so tx_o tracks the state register.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_b_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign tx_o           = r_tx;
  assign busy_o         = (r_state != S_IDLE);
  assign tx_done_tick_o = w_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) checked every cycle
// against a frame-level model built from tick counts and bit positions.
module tb_uart_tx;
  localparam int D = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       start [2];
  logic [7:0] din [2];
  logic       tx [2];
  logic       busy [2];
  logic       done [2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;
  int tick_per = 1;
  int tcnt = 0;

  bit         m_act [2];
  int         m_t [2];
  logic [7:0] m_w [2];

  always #5 clk = ~clk;

  uart_tx #(.DBit(D), .SbTick(16)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .tx_start_i(start[0]), .s_tick_i(tick),
    .din_i(din[0]), .tx_o(tx[0]), .busy_o(busy[0]), .tx_done_tick_o(done[0]));

  uart_tx #(.DBit(D), .SbTick(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .tx_start_i(start[1]), .s_tick_i(tick),
    .din_i(din[1]), .tx_o(tx[1]), .busy_o(busy[1]), .tx_done_tick_o(done[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int total(input int k);
    return 16 * (1 + D + P) + ((k == 0) ? 16 : 32);
  endfunction

  // Frame as a bit sequence: [start, d0..d7, (parity), stop...], 16 ticks per bit.
  function automatic logic line_exp(input int k);
    int idx;
    if (!m_act[k]) return 1'b1;
    idx = m_t[k] / 16;
    if (idx == 0) return 1'b0;
    if (idx <= D) return m_w[k][idx-1];
    if (P == 1 && idx == D + 1) return ^m_w[k];
    return 1'b1;
  endfunction

  function automatic logic done_exp(input int k);
    return m_act[k] && tick && (m_t[k] == total(k) - 1);
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] = 0;
      end else if (m_act[k]) begin
        if (tick) begin
          if (m_t[k] == total(k) - 1) m_act[k] = 0;
          else m_t[k]++;
        end
      end else if (start[k]) begin
        m_act[k] = 1;
        m_t[k]   = 0;
        m_w[k]   = din[k];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (tick_per <= 1) begin
      tick = 1'b1;
    end else begin
      tick = (tcnt == 0);
      tcnt = (tcnt + 1) % tick_per;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tx%0d", k), 32'(tx[k]), 32'(line_exp(k)));
        chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_act[k]));
        chk($sformatf("done%0d", k), 32'(done[k]), 32'(done_exp(k)));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fall(input int k, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx[k] === 1'b0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk($sformatf("fall_timeout%0d", k), 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int k, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[k] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk($sformatf("done_timeout%0d", k), 32'd0, 32'd1);
  endtask

  task automatic send0(input logic [7:0] w, output int f, output int d);
    din[0] = w;
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    wait_fall(0, 8, f);
    wait_done(0, 2000, d);
    step(1);
  endtask

  initial begin
    int f, d, f2, d2;
    logic [7:0] w;
    logic pexp;
    start[0] = 0; start[1] = 0; din[0] = 0; din[1] = 0;

    // Reset for 3 cycles, then idle
    rst = 1'b1;
    step(1);
    chk_en = 1;
    step(2);
    rst = 1'b0;
    step(200);

    // Tick every cycle, 0x55
    tick_per = 1;
    chk("idle_tx", 32'(tx[0]), 32'd1);
    send0(8'h55, f, d);
    chk("len_55", 32'(d - f + 1), 32'(total(0)));
    step(5);

    // Tick every 4 cycles, 0xA3: mid-bit samples
    tick_per = 4;
    w = 8'hA3;
    din[0] = w;
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    wait_fall(0, 8, f);
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(negedge clk);
      chk($sformatf("midbit%0d", i), 32'(tx[0]), 32'(w[i]));
    end
    wait_done(0, 2000, d);
    step(3);

    // Parity words, tick every cycle
    tick_per = 1;
    for (int j = 0; j < 2; j++) begin
      w = (j == 0) ? 8'h07 : 8'h03;
      pexp = (P == 1) ? ^w : 1'b1;
      din[0] = w;
      start[0] = 1'b1;
      step(1);
      start[0] = 1'b0;
      wait_fall(0, 8, f);
      repeat (16 * 9 + 8) @(negedge clk);
      chk($sformatf("parbit_%0h", w), 32'(tx[0]), 32'(pexp));
      wait_done(0, 2000, d);
      chk($sformatf("len_%0h", w), 32'(d - f + 1), 32'(total(0)));
      step(2);
    end

    // Reset in the middle of data bit 3 of 0xFF
    din[0] = 8'hFF;
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    repeat (16 * 4 + 8) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1);
    chk("rst_tx", 32'(tx[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    rst = 1'b0;
    step(2);
    send0(8'h3C, f, d);
    chk("len_after_rst", 32'(d - f + 1), 32'(total(0)));

    // Two stop bits, start held high: back-to-back 0x00 then 0xFF
    din[1] = 8'h00;
    start[1] = 1'b1;
    wait_fall(1, 8, f);
    din[1] = 8'hFF;
    wait_done(1, 2000, d);
    chk("len_b2b_a", 32'(d - f + 1), 32'(total(1)));
    wait_fall(1, 8, f2);
    chk("b2b_gap", 32'(f2 - d), 32'd2);
    step(1);
    start[1] = 1'b0;
    din[1] = 8'h5A;
    for (int i = 0; i < 40; i++) begin
      start[1] = ($urandom_range(0, 3) == 0);
      step(1);
    end
    start[1] = 1'b0;
    wait_done(1, 2000, d2);
    chk("len_b2b_b", 32'(d2 - f2 + 1), 32'(total(1)));
    step(3);

    // Randomized traffic on both instances
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) tick_per = $urandom_range(1, 4);
      for (int k = 0; k < 2; k++) begin
        start[k] = ($urandom_range(0, 15) == 0);
        din[k] = 8'($urandom);
      end
      rst = ($urandom_range(0, 999) == 0);
      step(1);
    end
    rst = 1'b0;
    start[0] = 0; start[1] = 0;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
